// File: rtl/pwm_ramp_ctl.sv
// pwm_ramp_ctl -- duty/direction ramp controller for one PWM channel.
//
// Accepts a target duty and direction, then walks the current duty toward
// it by STEP once per ramp tick (one PWM period). A direction change
// first ramps the duty down to zero, flips the direction, then ramps up.
//
// Handshake (cmd_*): a command transfers on a rising edge where
// cmd_valid=1 and cmd_ready=1. cmd_ready depends only on state and estop,
// never on cmd_valid. A source holds cmd_valid/cmd_duty/cmd_dir stable
// until the transfer edge.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   cmd_valid/ready command handshake
//   cmd_duty        target duty (0 = stop), saturated to DUTY_MAX
//   cmd_dir         target direction, 1 = positive rotation
//   estop           level-sensitive emergency stop
//   para_out        registered PWM interval value, (DUTY_MAX+1) - duty
//   dir_out         registered direction
//   busy            ramp or reversal in progress
//   at_target       current duty equals target (not during reversal)
//   dbg_state_o     current FSM state (IDLE=0, RAMP=1, STOPDIR=2, HOLD=3)

module pwm_ramp_ctl #(
    parameter int DUTY_MAX = 19998,
    parameter int STEP     = 100,
    parameter int TICK_DIV = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [14:0] cmd_duty,
    input  logic        cmd_dir,
    input  logic        estop,
    output logic [14:0] para_out,
    output logic        dir_out,
    output logic        busy,
    output logic        at_target,
    output logic [1:0]  dbg_state_o
);

    localparam int              CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]   TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [15:0]     STEP16    = 16'(STEP);
    localparam logic [15:0]     DMAX16    = 16'(DUTY_MAX);
    localparam logic [15:0]     PARA_OFF  = 16'(DUTY_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RAMP    = 2'd1,
        ST_STOPDIR = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [14:0]    duty_q, duty_d;
    logic [14:0]    target_q, target_d;
    logic           dir_q, dir_d;
    logic           pend_dir_q, pend_dir_d;
    logic [CW-1:0]  tick_cnt_q;
    logic [14:0]    para_q;
    logic           dir_out_q;

    logic           tick;
    logic           accept;
    logic [15:0]    duty16;
    logic [15:0]    target16;
    logic [15:0]    diff16;
    logic [14:0]    cmd_sat;

    assign tick     = (tick_cnt_q == TICK_LAST);
    assign duty16   = {1'b0, duty_q};
    assign target16 = {1'b0, target_q};
    assign diff16   = (target16 >= duty16) ? (target16 - duty16) : (duty16 - target16);
    assign cmd_sat  = ({1'b0, cmd_duty} > DMAX16) ? 15'(DUTY_MAX) : cmd_duty;

    assign cmd_ready   = ((state_q == ST_IDLE) || (state_q == ST_HOLD)) && !estop;
    assign accept      = cmd_valid && cmd_ready;
    assign busy        = (state_q == ST_RAMP) || (state_q == ST_STOPDIR);
    assign at_target   = (duty_q == target_q) && (state_q != ST_STOPDIR);
    assign para_out    = para_q;
    assign dir_out     = dir_out_q;
    assign dbg_state_o = state_q;

    always_comb begin
        state_d    = state_q;
        duty_d     = duty_q;
        target_d   = target_q;
        dir_d      = dir_q;
        pend_dir_d = pend_dir_q;

        if (estop) begin
            // Direction is kept: duty is forced to zero, so a later command
            // in either direction starts cleanly from standstill.
            duty_d   = '0;
            target_d = '0;
            state_d  = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_HOLD: begin
                    if (accept) begin
                        target_d = cmd_sat;
                        if ((cmd_dir != dir_q) && (duty_q != '0)) begin
                            pend_dir_d = cmd_dir;
                            state_d    = ST_STOPDIR;
                        end else begin
                            dir_d   = cmd_dir;
                            state_d = ST_RAMP;
                        end
                    end
                end
                ST_RAMP: begin
                    if (tick) begin
                        if (diff16 <= STEP16) begin
                            // Final step lands exactly on target, no overshoot.
                            duty_d  = target_q;
                            state_d = (target_q == '0) ? ST_IDLE : ST_HOLD;
                        end else if (target16 > duty16) begin
                            duty_d = 15'(duty16 + STEP16);
                        end else begin
                            duty_d = 15'(duty16 - STEP16);
                        end
                    end
                end
                ST_STOPDIR: begin
                    if (tick) begin
                        if (duty16 <= STEP16) begin
                            // Direction flips only on the edge duty becomes zero.
                            duty_d  = '0;
                            dir_d   = pend_dir_q;
                            state_d = ST_RAMP;
                        end else begin
                            duty_d = 15'(duty16 - STEP16);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            duty_q     <= '0;
            target_q   <= '0;
            dir_q      <= 1'b0;
            pend_dir_q <= 1'b0;
            tick_cnt_q <= '0;
            para_q     <= 15'(DUTY_MAX + 1);
            dir_out_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            target_q   <= target_d;
            dir_q      <= dir_d;
            pend_dir_q <= pend_dir_d;
            tick_cnt_q <= tick ? '0 : (tick_cnt_q + CW'(1));
            para_q     <= 15'(PARA_OFF - duty16);
            dir_out_q  <= dir_q;
        end
    end

endmodule

// File: doc/pwm_ramp_ctl.md
PWM_RAMP_CTL -- requirements
Module: pwm_ramp_ctl

Interface
REQ-001 SHALL have parameter DUTY_MAX, default 19998; maximum duty in PWM counter units.
REQ-002 SHALL have parameter STEP, default 100; duty change per ramp tick.
REQ-003 SHALL have parameter TICK_DIV, default 20000; clk cycles per ramp tick, equal to one PWM period.
REQ-004 SHALL have port clk  in  1  clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port cmd_valid  in  1  new target command present.
REQ-007 SHALL have port cmd_ready  out  1  command can be accepted this cycle.
REQ-008 SHALL have port cmd_duty  in  15  target duty, 0 = stop.
REQ-009 SHALL have port cmd_dir  in  1  target direction, 1 = positive rotation.
REQ-010 SHALL have port estop  in  1  emergency stop, level-sensitive.
REQ-011 SHALL have port para_out  out  15  interval value for the PWM channel.
REQ-012 SHALL have port dir_out  out  1  direction for the PWM channel.
REQ-013 SHALL have port busy  out  1  ramp or reversal in progress.
REQ-014 SHALL have port at_target  out  1  current duty equals target duty.

Function
REQ-015 SHALL hold internal registers duty_cur[14:0], target[14:0], pend_dir, dir_cur, a tick counter, and state in {IDLE, RAMP, STOPDIR, HOLD}.
REQ-016 Tick counter SHALL free-run 0..TICK_DIV-1 and wrap to 0.
REQ-017 tick SHALL be 1 for exactly the one cycle where the counter equals TICK_DIV-1.
REQ-018 para_out SHALL be registered and equal (DUTY_MAX+1) - duty_cur, one cycle after any duty_cur change; duty 0 therefore gives 19999, which is PWM off.
REQ-019 dir_out SHALL be the registered dir_cur.
REQ-020 cmd_ready SHALL be 1 only in IDLE or HOLD with estop=0.
REQ-021 A command SHALL be accepted when cmd_valid and cmd_ready are both 1.
REQ-022 An accepted cmd_duty SHALL be saturated to DUTY_MAX before being stored as target.
REQ-023 On accept with cmd_dir != dir_cur and duty_cur != 0: store pend_dir=cmd_dir and go to STOPDIR.
REQ-024 On accept otherwise: set dir_cur=cmd_dir and go to RAMP.
REQ-025 RAMP, on tick:
- if |target-duty_cur| <= STEP, set duty_cur=target and go to HOLD (IDLE if target=0);
- else move duty_cur STEP toward target.
REQ-026 RAMP SHALL not change duty_cur on non-tick cycles.
REQ-027 STOPDIR, on tick: duty_cur = max(duty_cur-STEP, 0).
REQ-028 In STOPDIR, on the same edge duty_cur reaches 0: set dir_cur=pend_dir and go to RAMP; the first increase occurs on the next tick.
REQ-029 dir_cur SHALL never change while duty_cur != 0.
REQ-030 Duty arithmetic SHALL use 16-bit intermediates; duty_cur SHALL never leave the range 0..DUTY_MAX.
REQ-031 estop=1 SHALL, on the next edge:
- force duty_cur=0, target=0, state IDLE;
- keep dir_cur;
- override any command acceptance and tick on the same cycle.
REQ-032 busy SHALL be 1 exactly in RAMP or STOPDIR.
REQ-033 at_target SHALL be 1 when duty_cur==target and state is not STOPDIR.
REQ-034 A command that re-issues the current target and direction SHALL go RAMP -> HOLD on the next tick with no duty change.

Reset
REQ-035 rst SHALL have priority over estop and commands.
REQ-036 While rst=1, on each edge the block SHALL set: duty_cur=0, target=0, dir_cur=0, pend_dir=0, tick counter=0, state IDLE.
REQ-037 Reset output values SHALL be: para_out=19999, dir_out=0, busy=0, at_target=1, cmd_ready=1 from the first cycle after rst deasserts.
REQ-038 rst asserted mid-ramp SHALL abandon the ramp with no further duty steps.

Verification (TICK_DIV=10, STEP=100, DUTY_MAX=19998)
REQ-039 Accel: cmd duty=250, dir=1 from reset -> duty_cur goes 100, 200, 250 on three successive ticks; para_out ends at 19749; then HOLD, busy=0, at_target=1.
REQ-040 Reversal: at duty 250 dir 1, cmd duty=150 dir=0 -> duty goes 150, 50, 0 with dir_out=1, then dir_out=0, then duty goes 100, 150; dir_out never toggles while duty != 0.
REQ-041 Saturation: cmd duty=32767 -> target=19998; final para_out=1; no overshoot on the last step.
REQ-042 Estop: estop=1 mid-ramp at duty 300 -> next cycle para_out=19999, state IDLE, cmd_ready=0 until estop=0.
REQ-043 Handshake: cmd_valid held high during RAMP -> cmd_ready=0; the command is accepted on the first HOLD cycle.
REQ-044 Reset: rst pulsed during STOPDIR -> all outputs at reset values; no dir change carried over.
